// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM skid pipeline register.
// Default field widths, the 2-bit occupancy state encoding and the
// payload layout (writeback bundle followed by memory bundle).
package ex_mem_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_ADDR_W_DEF = 32;
    localparam int ALUOP_W_DEF    = 8;

    // Occupancy of the two-entry buffer (main slot + hidden skid slot)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Payload layout at default widths; the top builds the same field order
    // with its own parameter values.
    typedef struct packed {
        logic [REG_ADDR_W_DEF-1:0] waddr;
        logic                      we;
        logic [DATA_W_DEF-1:0]     wdata;
        logic [MEM_ADDR_W_DEF-1:0] mem_addr;
        logic [ALUOP_W_DEF-1:0]    aluop;
        logic [DATA_W_DEF-1:0]     rt_data;
    } ex_mem_payload_t;

    // Total payload width for a given set of field widths
    function automatic int payload_width(input int addr_w, input int data_w,
                                         input int maddr_w, input int op_w);
        return addr_w + 1 + data_w + maddr_w + op_w + data_w;
    endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One payload register with clear / load / hold controls.
// Clear wins over load so an emptied slot always shows an all-zero NOP.
module ex_mem_slot
    import ex_mem_pkg::*;
#(
    parameter int W = payload_width(REG_ADDR_W_DEF, DATA_W_DEF,
                                    MEM_ADDR_W_DEF, ALUOP_W_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Payload register: reset/clear to zero, otherwise load or hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= {W{1'b0}};
        end else if (clr) begin
            q_r <= {W{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with valid/ready handshake and a one-entry skid
// slot. ex_ready is a flop (NOT skid occupied), so MEM back-pressure never
// reaches EX combinationally. Flush kills both slots and any offered op.
// Optional macro EX_MEM_SKID_PERF_EN adds saturating stall/bubble counters.
module ex_mem_skid
    import ex_mem_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
    parameter int ALUOP_W    = ALUOP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  ex_we,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [MEM_ADDR_W-1:0] ex_mem_addr,
    input  logic [ALUOP_W-1:0]    ex_mem_aluop,
    input  logic [DATA_W-1:0]     ex_rt_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] mem_waddr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [MEM_ADDR_W-1:0] mem_mem_addr,
    output logic [ALUOP_W-1:0]    mem_mem_aluop,
    output logic [DATA_W-1:0]     mem_rt_data
`ifdef EX_MEM_SKID_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_bubble_cnt
`endif
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic                  we;
        logic [DATA_W-1:0]     wdata;
        logic [MEM_ADDR_W-1:0] mem_addr;
        logic [ALUOP_W-1:0]    aluop;
        logic [DATA_W-1:0]     rt_data;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    skid_state_e state_r;
    skid_state_e state_nxt_s;
    logic        ex_ready_r;
    logic        mem_valid_r;

    logic        in_fire_s;
    logic        out_fire_s;
    logic        main_load_s;
    logic        main_clr_s;
    logic        main_from_skid_s;
    logic        skid_load_s;
    logic        skid_clr_s;

    payload_t    ex_payload_s;
    payload_t    main_d_s;
    payload_t    main_q_s;
    payload_t    skid_q_s;

    assign in_fire_s  = ex_valid & ex_ready_r;
    assign out_fire_s = mem_valid_r & mem_ready;

    // Gather the EX-side fields into one payload word
    always_comb begin
        ex_payload_s          = '0;
        ex_payload_s.waddr    = ex_waddr;
        ex_payload_s.we       = ex_we;
        ex_payload_s.wdata    = ex_wdata;
        ex_payload_s.mem_addr = ex_mem_addr;
        ex_payload_s.aluop    = ex_mem_aluop;
        ex_payload_s.rt_data  = ex_rt_data;
    end

    // Next-state and slot-control decode; flush overrides any handshake
    always_comb begin
        state_nxt_s      = state_r;
        main_load_s      = 1'b0;
        main_clr_s       = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clr_s       = 1'b0;
        if (flush) begin
            main_clr_s  = 1'b1;
            skid_clr_s  = 1'b1;
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_load_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_load_s = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else if (out_fire_s) begin
                        // Main drains with nothing behind it: show a NOP
                        main_clr_s  = 1'b1;
                        state_nxt_s = ST_EMPTY;
                    end else if (in_fire_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = ST_FULL;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clr_s       = 1'b1;
                        state_nxt_s      = ST_ONE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage
                    main_clr_s  = 1'b1;
                    skid_clr_s  = 1'b1;
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Main slot input: refill from the skid entry when draining from FULL
    always_comb begin
        if (main_from_skid_s) begin
            main_d_s = skid_q_s;
        end else begin
            main_d_s = ex_payload_s;
        end
    end

    // Occupancy FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            mem_valid_r <= 1'b0;
            ex_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            mem_valid_r <= (state_nxt_s != ST_EMPTY);
            ex_ready_r  <= (state_nxt_s != ST_FULL);
        end
    end

    ex_mem_slot #(.W(PAYLOAD_W)) u_main_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (main_clr_s),
        .load  (main_load_s),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    ex_mem_slot #(.W(PAYLOAD_W)) u_skid_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (skid_clr_s),
        .load  (skid_load_s),
        .d     (ex_payload_s),
        .q     (skid_q_s)
    );

    assign ex_ready      = ex_ready_r;
    assign mem_valid     = mem_valid_r;
    assign mem_waddr     = main_q_s.waddr;
    assign mem_we        = main_q_s.we;
    assign mem_wdata     = main_q_s.wdata;
    assign mem_mem_addr  = main_q_s.mem_addr;
    assign mem_mem_aluop = main_q_s.aluop;
    assign mem_rt_data   = main_q_s.rt_data;

`ifdef EX_MEM_SKID_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_bubble_r;

    // Saturating count of cycles MEM holds a valid op without accepting it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_r <= 32'd0;
        end else if (mem_valid_r && !mem_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
            perf_stall_r <= perf_stall_r + 32'd1;
        end else begin
            perf_stall_r <= perf_stall_r;
        end
    end

    // Saturating count of cycles the MEM side sees no valid op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_bubble_r <= 32'd0;
        end else if (!mem_valid_r && (perf_bubble_r != 32'hFFFF_FFFF)) begin
            perf_bubble_r <= perf_bubble_r + 32'd1;
        end else begin
            perf_bubble_r <= perf_bubble_r;
        end
    end

    assign perf_stall_cnt  = perf_stall_r;
    assign perf_bubble_cnt = perf_bubble_r;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: the driver pushes each op it expects to
// be delivered, a negedge monitor pops and compares on every MEM handshake.
module tb_ex_mem_skid;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] maddr;
        logic [7:0]  aluop;
        logic [31:0] rt;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic [31:0] ex_wdata;
    logic [31:0] ex_mem_addr;
    logic [7:0]  ex_mem_aluop;
    logic [31:0] ex_rt_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_mem_addr;
    logic [7:0]  mem_mem_aluop;
    logic [31:0] mem_rt_data;
`ifdef EX_MEM_SKID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] s0;
    logic [31:0] b0;
`endif

    int  tests = 0;
    int  fails = 0;
    op_t exp_q[$];
    op_t op_a, op_b, op_c, op_d, op_e;

    always #5 clk = ~clk;

    ex_mem_skid dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_waddr      (ex_waddr),
        .ex_we         (ex_we),
        .ex_wdata      (ex_wdata),
        .ex_mem_addr   (ex_mem_addr),
        .ex_mem_aluop  (ex_mem_aluop),
        .ex_rt_data    (ex_rt_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_waddr     (mem_waddr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_mem_addr  (mem_mem_addr),
        .mem_mem_aluop (mem_mem_aluop),
        .mem_rt_data   (mem_rt_data)
`ifdef EX_MEM_SKID_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    function automatic op_t dut_out();
        op_t o;
        o = {mem_waddr, mem_we, mem_wdata, mem_mem_addr, mem_mem_aluop, mem_rt_data};
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input op_t o);
        ex_valid     = 1'b1;
        ex_waddr     = o.waddr;
        ex_we        = o.we;
        ex_wdata     = o.wdata;
        ex_mem_addr  = o.maddr;
        ex_mem_aluop = o.aluop;
        ex_rt_data   = o.rt;
    endtask

    task automatic idle();
        ex_valid     = 1'b0;
        ex_waddr     = 5'd0;
        ex_we        = 1'b0;
        ex_wdata     = 32'd0;
        ex_mem_addr  = 32'd0;
        ex_mem_aluop = 8'd0;
        ex_rt_data   = 32'd0;
    endtask

    // Monitor: every MEM handshake must match the oldest expected op
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_op: got %0h expected none", dut_out());
            end else begin
                check("fifo_payload", dut_out(), exp_q.pop_front());
            end
        end
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        op_a = {5'd3,  1'b1, 32'h0000_0011, 32'h0000_1000, 8'h23, 32'hAAAA_0001};
        op_b = {5'd4,  1'b1, 32'h0000_0022, 32'h0000_1004, 8'h2B, 32'hBBBB_0002};
        op_c = {5'd31, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 8'hFF, 32'hFFFF_FFFF};
        op_d = {5'd7,  1'b1, 32'hDEAD_BEEF, 32'h0000_2000, 8'h0D, 32'h1234_5678};
        op_e = {5'd9,  1'b1, 32'h5555_AAAA, 32'h8000_0000, 8'h80, 32'h0000_0001};

        // Reset with an op offered
        rst_n     = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        offer(op_a);
        tick();
        tick();
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_payload", dut_out(), 110'd0);
        rst_n = 1'b1;
        idle();
        tick();
        check("rst_ex_ready", ex_ready, 1'b1);
        check("rst_still_empty", mem_valid, 1'b0);

        // Streaming A, B, C back-to-back with MEM always ready
        mem_ready = 1'b1;
        offer(op_a); exp_q.push_back(op_a); tick();
        check("stream_valid_a", mem_valid, 1'b1);
        check("stream_ready_a", ex_ready, 1'b1);
        offer(op_b); exp_q.push_back(op_b); tick();
        check("stream_valid_b", mem_valid, 1'b1);
        check("stream_ready_b", ex_ready, 1'b1);
        offer(op_c); exp_q.push_back(op_c); tick();
        check("stream_valid_c", mem_valid, 1'b1);
        check("stream_ready_c", ex_ready, 1'b1);
        idle(); tick();
        check("stream_drained", exp_q.size(), 0);
        check("bubble_valid", mem_valid, 1'b0);
        check("bubble_waddr", mem_waddr, 5'd0);
        check("bubble_wdata", mem_wdata, 32'd0);
        check("bubble_aluop", mem_mem_aluop, 8'd0);
        check("bubble_we", mem_we, 1'b0);

        // Stall: A in main, B into skid, hold 3 cycles
        mem_ready = 1'b0;
        offer(op_a); exp_q.push_back(op_a); tick();
        check("stall_ready_one", ex_ready, 1'b1);
        offer(op_b); exp_q.push_back(op_b); tick();
        check("stall_ready_full", ex_ready, 1'b0);
        check("stall_main_a", dut_out(), op_a);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_payload", dut_out(), op_a);
            check("stall_hold_valid", mem_valid, 1'b1);
            check("stall_hold_ready", ex_ready, 1'b0);
        end
        mem_ready = 1'b1;
        tick();
        check("skid_to_main_b", dut_out(), op_b);
        check("skid_ready_back", ex_ready, 1'b1);
        tick();
        check("skid_drained", exp_q.size(), 0);
        check("skid_empty", mem_valid, 1'b0);

        // Flush while FULL with op D offered
        mem_ready = 1'b0;
        offer(op_c); exp_q.push_back(op_c); tick();
        offer(op_e); exp_q.push_back(op_e); tick();
        check("flush_pre_full", ex_ready, 1'b0);
        flush = 1'b1;
        offer(op_d);
        tick();
        flush = 1'b0;
        idle();
        exp_q.delete();
        check("flush_valid", mem_valid, 1'b0);
        check("flush_we", mem_we, 1'b0);
        check("flush_payload", dut_out(), 110'd0);
        check("flush_ready", ex_ready, 1'b1);

        // Flush while EMPTY with ex_ready=1: the offered op is discarded
        mem_ready = 1'b1;
        flush = 1'b1;
        offer(op_d);
        tick();
        flush = 1'b0;
        idle();
        check("flush_empty_valid", mem_valid, 1'b0);
        tick();
        tick();
        check("flush_no_ghost", mem_valid, 1'b0);

`ifdef EX_MEM_SKID_PERF_EN
        // Perf counters: 3 empty edges, 5 stall edges, then flush
        mem_ready = 1'b0;
        s0 = perf_stall_cnt;
        b0 = perf_bubble_cnt;
        tick();
        tick();
        offer(op_a); exp_q.push_back(op_a); tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check("perf_stall_5", perf_stall_cnt - s0, 32'd5);
        check("perf_bubble_3", perf_bubble_cnt - b0, 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("perf_stall_flush", perf_stall_cnt - s0, 32'd6);
        check("perf_bubble_flush", perf_bubble_cnt - b0, 32'd3);
        tick();
        check("perf_stall_after", perf_stall_cnt - s0, 32'd6);
        check("perf_bubble_after", perf_bubble_cnt - b0, 32'd4);
        mem_ready = 1'b1;
`endif

        tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Parametrised EX→MEM pipeline register carrying the writeback bundle (waddr, we, wdata) and memory bundle (mem_addr, aluop, rt_data).
- Adds a valid/ready handshake and a one-entry skid slot, so a multi-cycle MEM stage can stall without a combinational ready path back into EX.
- Adds a flush that kills in-flight ops on a branch or exception.

Parameters:
REG_ADDR_W, 5, register-file address width
DATA_W, 32, register/data width (wdata, rt_data)
MEM_ADDR_W, 32, data-memory address width
ALUOP_W, 8, aluop width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  kill all held ops this cycle
ex_valid  in  1  EX presents an op
ex_ready  out  1  block can accept an op
ex_waddr  in  REG_ADDR_W  destination register
ex_we  in  1  register write enable
ex_wdata  in  DATA_W  writeback data
ex_mem_addr  in  MEM_ADDR_W  memory address
ex_mem_aluop  in  ALUOP_W  memory op code
ex_rt_data  in  DATA_W  store data
mem_valid  out  1  MEM-side op valid
mem_ready  in  1  MEM stage accepts the op
mem_waddr  out  REG_ADDR_W  registered copy
mem_we  out  1  registered copy
mem_wdata  out  DATA_W  registered copy
mem_mem_addr  out  MEM_ADDR_W  registered copy
mem_mem_aluop  out  ALUOP_W  registered copy
mem_rt_data  out  DATA_W  registered copy

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on posedge clk). While rst_n=0 at an edge:
  - all mem_* outputs ← 0, mem_valid ← 0;
  - skid slot cleared; ex_ready ← 1 from the next cycle.
- Handshakes:
  - in_fire = ex_valid & ex_ready; out_fire = mem_valid & mem_ready.
  - ex_ready is a register, equal to NOT skid_valid. It never depends combinationally on mem_ready.
- Storage: main slot drives the mem_* outputs directly; skid slot is hidden.
- States:
  - EMPTY: mem_valid=0. in_fire → ONE, main loads ex_*.
  - ONE:
    - in_fire & out_fire → ONE, main reloads.
    - out_fire only → EMPTY.
    - in_fire only → FULL, skid loads ex_*.
    - neither → hold.
  - FULL: ex_ready=0. out_fire → ONE, main ← skid, skid cleared.
- Latency: 1 cycle from in_fire to mem_valid when the block is not full. Order is strictly FIFO; no op is duplicated or dropped except by flush.
- Bubble semantics: whenever the main slot becomes empty, all mem_* payload registers clear to 0. An empty stage therefore presents mem_we=0 and aluop=0 (NOP).
- Flush:
  - Priority: reset > flush > handshake.
  - Effect: both slots cleared, state → EMPTY, payload → 0, ex_ready → 1.
  - An input offered in the flush cycle is discarded, even if ex_ready=1.
- Payload stability: while mem_valid=1 and mem_ready=0, the mem_* outputs must hold stable.
- Widths: pure transport, no arithmetic; every field is passed bit-exact.

Optional Feature:
- Macro: EX_MEM_SKID_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_stall_cnt increments each cycle with mem_valid & ~mem_ready.
  - perf_bubble_cnt increments each cycle with ~mem_valid.
  - Both saturate at 0xFFFF_FFFF, reset to 0, and are unaffected by flush.
- Undefined: the ports and counters are absent, with no other behavioural difference.

Decomposition:
- Package ex_mem_pkg holds:
  - default width constants;
  - 2-bit state encoding (EMPTY=0, ONE=1, FULL=2);
  - a packed payload struct type {waddr, we, wdata, mem_addr, aluop, rt_data}.
- One sub-module, ex_mem_slot: a payload register with load, clear and hold controls. It is instantiated twice (main and skid); the top holds the FSM and handshake.

Test Plan:
- Reset: rst_n=0 for 2 cycles with ex_valid=1, ex_we=1 → all mem_* =0, mem_valid=0; ex_ready=1 on the first cycle after release.
- Streaming: mem_ready=1, ops A (waddr=3, wdata=0x11), B (waddr=4, wdata=0x22), C on consecutive cycles → each appears 1 cycle later; mem_valid is continuous; ex_ready stays 1.
- Stall/skid: A accepted, mem_ready=0, B offered → B goes to skid, ex_ready=0. Hold 3 cycles → mem_* stays A. mem_ready=1 → A leaves, then B; no loss or reorder; ex_ready returns to 1.
- Flush in FULL: flush=1 with ex_valid=1 (op D) → next cycle mem_valid=0, mem_we=0, all payload 0, ex_ready=1; D never appears.
- Bubble: single op A then ex_valid=0, mem_ready=1 → after A drains, mem_waddr=0, mem_wdata=0, mem_mem_aluop=0.
- Perf (with EX_MEM_SKID_PERF_EN): 5 stall cycles plus 2 empty cycles after reset release → perf_stall_cnt=5, perf_bubble_cnt≥2; a flush leaves both counts unchanged.
